ex_hazard_ctrl: RTL

//  Sequences the EX-stage ALU of the 5-stage pipeline. Computes the ALU forwardA/forwardB selects one

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_match.sv | 38 +++
 rtl/ex_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the EX-stage hazard controller: forwarding select
// codes, FSM state encodings and the default register index width.
package hazard_pkg;

    localparam int REG_AW = 5;

    // ALU operand source selects registered into ID/EX
    localparam logic [1:0] FWD_REG   = 2'b00;  // register file / immediate
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM ALUResult
    localparam logic [1:0] FWD_WB    = 2'b01;  // RegWriteData from MEM/WB

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_LU_STALL = 2'd1;
    localparam state_t ST_MC_WAIT  = 2'd2;

endpackage

// File: rtl/hazard_match.sv
// Per-source RAW detector: compares one ID source register against the EX and
// MEM destinations and priority-encodes the forwarding select.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          valid,
    input  logic          use_rs,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regwrite,
    output logic          hit_ex,
    output logic [1:0]    sel
);

    logic live;
    logic hit_mem;

    // x0 is hard-wired zero, so it never carries a dependency
    assign live    = valid & use_rs & (rs != '0);
    assign hit_ex  = live & ex_regwrite  & (ex_rd  == rs);
    assign hit_mem = live & mem_regwrite & (mem_rd == rs);

    // EX/MEM holds the younger producer, so it wins over MEM/WB
    always_comb begin
        // NOTE: default assignment first so no path leaves sel unassigned (no latch).
        sel = FWD_REG;
        if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding selects, load-use and mul/div stalls,
// branch flushes and the start/done handshake of the iterative mul/div unit.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without it
// the selects are tied to the register file and every RAW dependency stalls.
module ex_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MC_MAX_CYC = 64,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_mc,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              br_taken,
    input  logic              mc_done,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              hold_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              mc_start,
    output logic              mc_err,
    output logic [PERF_W-1:0] stall_cnt
);

    import hazard_pkg::*;

    localparam int                BUSY_W     = $clog2(MC_MAX_CYC + 1);
    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(MC_MAX_CYC);

    state_t            state;
    state_t            state_nxt;
    logic [BUSY_W-1:0] busy_cnt;
    logic              hit_ex_a;
    logic              hit_ex_b;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              dep_stall;
    logic              mc_enter;
    logic              mc_timeout;

    hazard_match #(.AW(REG_AW)) u_match_a (
        .valid        (id_valid),
        .use_rs       (id_use_rs1),
        .rs           (id_rs1),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .hit_ex       (hit_ex_a),
        .sel          (sel_a)
    );

    hazard_match #(.AW(REG_AW)) u_match_b (
        .valid        (id_valid),
        .use_rs       (id_use_rs2),
        .rs           (id_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .hit_ex       (hit_ex_b),
        .sel          (sel_b)
    );

`ifdef HAZARD_FWD_EN
    // Only a load in EX has no forwardable result yet
    assign dep_stall = ex_memread & (hit_ex_a | hit_ex_b);
`else
    // Without bypass paths a load or ALU producer in EX, or any producer in
    // MEM, must reach the write-through register file before ID may read it
    assign dep_stall = (ex_memread & (hit_ex_a | hit_ex_b))
                     | (~ex_memread & (hit_ex_a | hit_ex_b))
                     | (sel_a == FWD_WB) | (sel_b == FWD_WB);
`endif

    // Redirects squash the two youngest stages in the cycle they resolve
    assign flush_if_id = rst_n & br_taken;
    assign flush_id_ex = rst_n & br_taken;

    // FSM next state and stall/bubble/hold strobes; LU_STALL re-evaluates
    // dependencies like IDLE so a multi-cycle RAW wait simply stays there
    always_comb begin
        state_nxt    = state;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        hold_ex      = 1'b0;
        mc_enter     = 1'b0;
        mc_timeout   = 1'b0;
        if (rst_n) begin
            if (state == ST_MC_WAIT && !mc_done && busy_cnt < BUSY_LIMIT) begin
                stall_if_id = 1'b1;
                hold_ex     = 1'b1;
            end else begin
                // Leaving MC_WAIT without mc_done means the watchdog fired
                mc_timeout = (state == ST_MC_WAIT) && !mc_done;
                state_nxt  = ST_IDLE;
                if (br_taken) begin
                    state_nxt = ST_IDLE;
                end else if (dep_stall) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_nxt    = ST_LU_STALL;
                end else if (id_valid && id_is_mc) begin
                    mc_enter  = 1'b1;
                    state_nxt = ST_MC_WAIT;
                end
            end
        end
    end

    // FSM state, mul/div start pulse, busy watchdog and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mc_start  <= 1'b0;
            mc_err    <= 1'b0;
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            mc_start <= mc_enter;
            if (mc_enter) begin
                busy_cnt <= '0;
            end else if (state == ST_MC_WAIT) begin
                busy_cnt <= busy_cnt + BUSY_W'(1);
            end
            if (mc_timeout) begin
                mc_err <= 1'b1;
            end
            if (stall_if_id && (stall_cnt != {PERF_W{1'b1}})) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

`ifdef HAZARD_FWD_EN
    // ALU selects follow the ID instruction into EX; bubbles carry no operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            forwardA <= FWD_REG;
            forwardB <= FWD_REG;
        end else if (bubble_id_ex || flush_id_ex) begin
            forwardA <= FWD_REG;
            forwardB <= FWD_REG;
        end else if (!hold_ex) begin
            forwardA <= sel_a;
            forwardB <= sel_b;
        end
    end
`else
    assign forwardA = FWD_REG;
    assign forwardB = FWD_REG;
`endif

    // A redirect while the mul/div owns EX cannot occur in a legal pipeline
    a_no_br_in_mc: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == ST_MC_WAIT && br_taken));

endmodule
